// File: rtl/mem_bus_responder.sv
// Memory-bus responder with programmable wait states and a word-organised RAM.
// Supports byte and word accesses; out-of-range addresses complete without effect.
module mem_bus_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] MemAddr,
  input  logic        MemLength,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        MemEnable,
  input  logic [31:0] toMemData,
  output logic        MemRdy,
  output logic [31:0] fromMemData,
  output logic        Busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BUS_AW = 24;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic [BUS_AW-1:0] addr;
    logic              len;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            r_state;
  state_t            w_state_nxt;
  req_t              r_req;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rdy;
  logic              r_busy;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_capture;
  logic              w_commit;
  logic              w_rdy_nxt;
  logic              w_busy_nxt;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic              w_oor;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_wr_word;
  logic              w_do_rd;
  logic              w_do_wr;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (MemEnable)        w_state_nxt = S_WAIT;
      S_WAIT:    if (r_cnt == '0)      w_state_nxt = S_DONE;
      S_DONE:                          w_state_nxt = S_RELEASE;
      S_RELEASE: if (!MemEnable)       w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode; next values for the registered outputs
  always_comb begin
    w_capture  = 1'b0;
    w_commit   = 1'b0;
    w_rdy_nxt  = 1'b0;
    w_busy_nxt = 1'b0;
    if (r_state == S_IDLE && MemEnable)  w_capture = 1'b1;
    if (r_state == S_WAIT && r_cnt == '0) w_commit = 1'b1;
    w_rdy_nxt  = w_commit;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Request capture and wait-state counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_req <= '0;
      r_cnt <= '0;
    end else if (w_capture) begin
      r_req <= '{addr: MemAddr, len: MemLength, rd: MemRd, wr: MemWr, wdata: toMemData};
      r_cnt <= CNT_W'(WAIT_CYCLES);
    end else if (r_state == S_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Address decode; a read wins over a simultaneous write
  always_comb begin
    w_idx   = r_req.addr[ADDR_W+1:2];
    w_lane  = r_req.addr[1:0];
    w_oor   = |r_req.addr[BUS_AW-1:ADDR_W+2];
    w_word  = r_mem[w_idx];
    w_do_rd = w_commit && r_req.rd;
    w_do_wr = w_commit && r_req.wr && !r_req.rd && !w_oor;
  end

  // Read data selection (little-endian byte lanes)
  always_comb begin
    w_rd_data = '0;
    if (!w_oor) begin
      if (r_req.len) begin
        w_rd_data = w_word;
      end else begin
        unique case (w_lane)
          2'd0: w_rd_data = {24'b0, w_word[7:0]};
          2'd1: w_rd_data = {24'b0, w_word[15:8]};
          2'd2: w_rd_data = {24'b0, w_word[23:16]};
          2'd3: w_rd_data = {24'b0, w_word[31:24]};
          default: w_rd_data = '0;
        endcase
      end
    end
  end

  // Write data merge: byte writes replace only the addressed lane
  always_comb begin
    w_wr_word = w_word;
    if (r_req.len) begin
      w_wr_word = r_req.wdata;
    end else begin
      unique case (w_lane)
        2'd0: w_wr_word[7:0]   = r_req.wdata[7:0];
        2'd1: w_wr_word[15:8]  = r_req.wdata[7:0];
        2'd2: w_wr_word[23:16] = r_req.wdata[7:0];
        2'd3: w_wr_word[31:24] = r_req.wdata[7:0];
        default: w_wr_word = w_word;
      endcase
    end
  end

  // RAM array is intentionally not reset
  always_ff @(posedge Clk) begin
    if (w_do_wr) r_mem[w_idx] <= w_wr_word;
  end

  // Registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rdy  <= w_rdy_nxt;
      r_busy <= w_busy_nxt;
      if (w_do_rd) r_rdata <= w_rd_data;
    end
  end

  assign MemRdy      = r_rdy;
  assign Busy        = r_busy;
  assign fromMemData = r_rdata;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed scoreboard bench for mem_bus_responder at WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_mem_bus_responder;

  logic        clk;
  logic        rst_n;
  logic [23:0] addr;
  logic        len;
  logic        rd;
  logic        wr;
  logic        en2;
  logic        en0;
  logic [31:0] wdata;
  logic        rdy2, rdy0;
  logic        busy2, busy0;
  logic [31:0] rdat2, rdat0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model [2][1024];
  logic [31:0] last_rd [2];
  logic [31:0] exp_q [$];

  mem_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .Clk(clk), .Reset(rst_n), .MemAddr(addr), .MemLength(len), .MemRd(rd), .MemWr(wr),
    .MemEnable(en2), .toMemData(wdata), .MemRdy(rdy2), .fromMemData(rdat2), .Busy(busy2)
  );

  mem_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .Reset(rst_n), .MemAddr(addr), .MemLength(len), .MemRd(rd), .MemWr(wr),
    .MemEnable(en0), .toMemData(wdata), .MemRdy(rdy0), .fromMemData(rdat0), .Busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic get_rdy(input bit s);
    return s ? rdy0 : rdy2;
  endfunction

  function automatic logic get_busy(input bit s);
    return s ? busy0 : busy2;
  endfunction

  function automatic logic [31:0] get_rdat(input bit s);
    return s ? rdat0 : rdat2;
  endfunction

  task automatic set_en(input bit s, input logic v);
    if (s) en0 = v;
    else   en2 = v;
  endtask

  function automatic logic [31:0] model_read(input bit s, input logic [23:0] a, input bit l);
    logic [31:0] w;
    logic [1:0]  lane;
    if (a[23:12] != 12'h0) return 32'h0;
    w    = model[s][a[11:2]];
    lane = a[1:0];
    if (l) return w;
    return {24'h0, w[8*lane +: 8]};
  endfunction

  task automatic model_write(input bit s, input logic [23:0] a, input bit l, input logic [31:0] d);
    logic [31:0] w;
    logic [1:0]  lane;
    if (a[23:12] != 12'h0) return;
    w    = model[s][a[11:2]];
    lane = a[1:0];
    if (l) w = d;
    else   w[8*lane +: 8] = d[7:0];
    model[s][a[11:2]] = w;
  endtask

  // One complete handshake; hold = extra cycles MemEnable stays high after MemRdy
  task automatic access(input bit s, input logic [23:0] a, input bit l, input bit r,
                        input bit w, input logic [31:0] d, input int hold);
    int lat;
    bit seen;
    if (r)      exp_q.push_back(model_read(s, a, l));
    else if (w) model_write(s, a, l, d);
    @(negedge clk);
    addr = a; len = l; rd = r; wr = w; wdata = d;
    set_en(s, 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (get_rdy(s)) seen = 1'b1;
      if (lat == 1) begin
        addr  = a ^ 24'h000004;
        wdata = ~d;
        len   = ~l;
      end
    end
    check("rdy_latency", 32'(lat), s ? 32'd2 : 32'd4);
    if (r) last_rd[s] = exp_q.pop_front();
    check("read_data", get_rdat(s), last_rd[s]);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_no_rdy", 32'(get_rdy(s)), 32'd0);
      check("hold_busy", 32'(get_busy(s)), 32'd1);
    end
    @(negedge clk);
    set_en(s, 1'b0);
    if (hold == 0) begin
      @(posedge clk); #1;
      check("rdy_one_cycle", 32'(get_rdy(s)), 32'd0);
      check("busy_in_release", 32'(get_busy(s)), 32'd1);
    end
    @(posedge clk); #1;
    check("busy_fall", 32'(get_busy(s)), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; len = 1'b0; rd = 1'b0; wr = 1'b0; wdata = '0;
    en2 = 1'b0; en0 = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      model[0][i] = 32'h0;
      model[1][i] = 32'h0;
    end
    #1;
    check("rst_rdy", 32'(rdy2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_rdata", rdat2, 32'h0);
    check("rst_busy0", 32'(busy0), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Word and byte traffic
    access(0, 24'h000000, 1, 0, 1, 32'h0BADF00D, 0);
    access(0, 24'h000010, 1, 0, 1, 32'hDEADBEEF, 0);
    access(0, 24'h000010, 1, 1, 0, 32'h0, 0);
    access(0, 24'h000013, 0, 0, 1, 32'h000000A5, 0);
    access(0, 24'h000010, 1, 1, 0, 32'h0, 0);
    access(0, 24'h000011, 0, 1, 0, 32'h0, 0);
    access(0, 24'h000013, 0, 1, 0, 32'h0, 0);

    // Out-of-range write and read, then word 0 must be intact
    access(0, 24'h001000, 1, 0, 1, 32'h12345678, 0);
    access(0, 24'h001000, 1, 1, 0, 32'h0, 0);
    access(0, 24'h000000, 1, 1, 0, 32'h0, 0);

    // Request held high well past completion
    access(0, 24'h000010, 1, 1, 0, 32'h0, 10);

    // Reset during WAIT aborts the pending write
    access(0, 24'h000020, 1, 0, 1, 32'h11111111, 0);
    @(negedge clk);
    addr = 24'h000020; len = 1'b1; rd = 1'b0; wr = 1'b1; wdata = 32'hCAFEF00D; en2 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy2), 32'd0);
    check("abort_rdy", 32'(rdy2), 32'd0);
    check("abort_rdata", rdat2, 32'h0);
    en2 = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_rdy", 32'(rdy2), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 24'h000020, 1, 1, 0, 32'h0, 0);

    // Read+write together acts as a read; no-op request completes quietly
    access(0, 24'h000010, 1, 1, 1, 32'hFFFFFFFF, 0);
    access(0, 24'h000010, 1, 0, 0, 32'h0, 0);
    access(0, 24'h000010, 1, 1, 0, 32'h0, 0);

    // Zero wait states
    access(1, 24'h000010, 1, 0, 1, 32'h55AA55AA, 0);
    access(1, 24'h000010, 1, 1, 1, 32'hFFFFFFFF, 0);
    access(1, 24'h000012, 0, 1, 0, 32'h0, 0);
    access(1, 24'h000010, 1, 1, 0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the processor memory bus: it accepts read/write requests from the Processor initiator, inserts a programmable number of wait states, performs the access on an internal word-organised RAM and signals completion with MemRdy. It replaces the zero-wait-state Memory model in system builds that must exercise the processor's wait-for-ready logic. Byte and word accesses are supported. Out-of-range addresses complete harmlessly.

## Interface
- ADDR_W, 10: word-address width of the internal RAM. Depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states inserted per access. Legal range 0..15.
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MemAddr  in  24  byte address. Word index is MemAddr[ADDR_W+1:2]; byte lane is MemAddr[1:0].
- MemLength  in  1  1 = 32-bit word access, 0 = 8-bit byte access.
- MemRd  in  1  read request qualifier.
- MemWr  in  1  write request qualifier.
- MemEnable  in  1  request strobe; held high by the initiator until it sees MemRdy.
- toMemData  in  32  write data; for byte writes, bits [7:0] are used.
- MemRdy  out  1  one-cycle completion pulse.
- fromMemData  out  32  read data; registered and held until the next read completes.
- Busy  out  1  high from request acceptance until the responder returns to IDLE.

## Operation
- FSM states: IDLE, WAIT, DONE, RELEASE.
- IDLE: when MemEnable=1 is sampled, capture MemAddr, MemLength, MemRd, MemWr and toMemData into request registers, then go to WAIT. Input changes after capture are ignored for that access.
- WAIT: a 4-bit counter loads WAIT_CYCLES on capture and decrements each edge. When the counter reads 0, the access executes on that edge and the FSM goes to DONE.
- DONE: MemRdy=1 for exactly one cycle; the next edge goes to RELEASE.
- RELEASE: stay while MemEnable=1; when MemEnable=0 is sampled, go to IDLE. A request held high therefore never re-triggers.
- Word read: fromMemData is the RAM word. MemAddr[1:0] is ignored, so the access is forced aligned.
- Word write: the whole word is written from toMemData.
- Byte read: fromMemData = {24'b0, selected byte}. Lane 0 is bits [7:0] and lane 3 is bits [31:24] (little-endian).
- Byte write: only the addressed lane is written, with toMemData[7:0]; the other lanes are unchanged.
- Out of range means MemAddr[23:ADDR_W+2] is nonzero:
  - reads return 32'b0;
  - writes are dropped;
  - timing and MemRdy are unchanged.
- MemRd=1 and MemWr=1 together: the access is treated as a read and the write is suppressed.
- MemRd=0 and MemWr=0 with MemEnable=1: the access completes with MemRdy; no RAM or fromMemData change.
- fromMemData updates only on completing reads.

## Timing
- Reset asserted (Reset=0): state goes to IDLE immediately. MemRdy=0, Busy=0, fromMemData=32'h0, counter=0, request registers cleared.
- RAM contents are not reset.
- Reset mid-access aborts the access. A pending write is not performed, because writes commit only on the WAIT→DONE edge.
- Latency: MemEnable is sampled high at edge E0. The access commits at edge E0+WAIT_CYCLES+1, and MemRdy is high for the cycle following that edge.
- With WAIT_CYCLES=0, MemRdy is high in the cycle after E0+1.
- Busy rises after E0 and falls after the edge where RELEASE samples MemEnable=0.
- Minimum spacing between back-to-back requests: MemEnable must be low for at least one sampled edge in RELEASE.
- The earliest next capture is the edge after return to IDLE.
- If MemEnable drops before the FSM reaches DONE, the access still completes and MemRdy still pulses. The FSM then exits RELEASE on the next edge.

## Test plan
- Reset with WAIT_CYCLES=2. Word write 32'hDEADBEEF to address 24'h000010, then word read of 24'h000010. Required: MemRdy pulses 3 edges after each capture, lasting one cycle; read returns 32'hDEADBEEF.
- Byte write 8'hA5 to 24'h000013, then word read of 24'h000010. Required: 32'hA5ADBEEF. Byte read of 24'h000011 returns 32'h000000BE.
- Out-of-range address with ADDR_W=10: word write 32'h12345678 to 24'h001000, then read it back. Required: read returns 32'h0; word 0 unchanged; MemRdy timing normal.
- Hold MemEnable high for 10 cycles after MemRdy. Required: exactly one MemRdy pulse, Busy stays high until MemEnable drops, and no second access occurs.
- Assert Reset mid-WAIT of a word write of 32'hCAFEF00D to 24'h000020, where the location previously held 32'h11111111. Required: MemRdy stays 0, Busy goes 0 immediately, and a later read returns 32'h11111111.
- MemRd=1 and MemWr=1 with data 32'hFFFFFFFF to 24'h000010. Required: returns the old word and the RAM is unchanged. Repeat at WAIT_CYCLES=0: MemRdy is high in the cycle after E0+1.
